// File: rtl/taxi_trip_ctrl.sv
// Purpose: taxi trip sequencer (vacant -> meter clear -> hired -> fare display), wait-mode timing, distance pulse gating.
// Latency: all outputs registered; control outputs change on the same edge as state, pulse_out lags the sensor by one cycle.
// Backpressure: none; buttons and distance pulses are single-cycle strobes, ignored in states where they have no meaning.
module taxi_trip_ctrl #(
    parameter int unsigned SLOW_TICKS    = 5000,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned DISPLAY_TICKS = 30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        distance_pulse_10m,
    input  logic        btn_hire,
    input  logic        btn_end,
    input  logic        btn_pay,
    input  logic [31:0] meter_total,
    output logic        meter_clr,
    output logic        meter_en,
    output logic        pulse_out,
    output logic        wait_mode,
    output logic [31:0] wait_ticks,
    output logic [1:0]  state,
    output logic [31:0] fare,
    output logic        fare_valid,
    output logic        vacant_lamp,
    output logic [15:0] trip_count
);

    typedef enum logic [1:0] {
        ST_VACANT = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_HIRED  = 2'd2,
        ST_FARE   = 2'd3
    } state_e;

    // Counter widths sized so each counter can hold its terminal value.
    localparam int CLR_W  = $clog2(CLR_CYCLES + 1);
    localparam int DISP_W = $clog2(DISPLAY_TICKS + 1);
    localparam int GAP_W  = $clog2(SLOW_TICKS + 1);

    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISPLAY_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(SLOW_TICKS);

    state_e             state_q, state_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DISP_W-1:0]  disp_cnt_q, disp_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [31:0]        wait_ticks_q, wait_ticks_d;
    logic [31:0]        fare_q, fare_d;
    logic [15:0]        trip_count_q, trip_count_d;
    logic               meter_clr_q, meter_clr_d;
    logic               meter_en_q, meter_en_d;
    logic               fare_valid_q, fare_valid_d;
    logic               vacant_lamp_q, vacant_lamp_d;
    logic               wait_mode_q, wait_mode_d;
    logic               pulse_out_q, pulse_out_d;

    // Trip sequencing: each state only listens to the button that makes sense there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_VACANT: if (btn_hire) state_d = ST_CLEAR;
            ST_CLEAR:  if (clr_cnt_q == CLR_LAST) state_d = ST_HIRED;
            // End beats a simultaneous hire because hire is simply not decoded here.
            ST_HIRED:  if (btn_end) state_d = ST_FARE;
            ST_FARE:   if (btn_pay || (disp_cnt_q == DISP_LAST)) state_d = ST_VACANT;
            default:   state_d = ST_VACANT;
        endcase
    end

    // Dwell counters, distance-gap tracking, fare latch and trip statistics.
    always_comb begin
        clr_cnt_d     = '0;
        disp_cnt_d    = '0;
        gap_d         = gap_q;
        wait_ticks_d  = wait_ticks_q;
        fare_d        = fare_q;
        trip_count_d  = trip_count_q;
        pulse_out_d   = distance_pulse_10m && (state_q == ST_HIRED);

        // Counters restart from zero on entry and count only while staying put.
        if ((state_q == ST_CLEAR) && (state_d == ST_CLEAR)) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
        end
        if ((state_q == ST_FARE) && (state_d == ST_FARE)) begin
            disp_cnt_d = disp_cnt_q + 1'b1;
        end

        // Gap since the last 10 m pulse; only meaningful while hired.
        if (distance_pulse_10m || (state_q != ST_HIRED)) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end

        // Wait time belongs to one trip: zeroed during the clear phase, frozen outside HIRED.
        if (state_q == ST_CLEAR) begin
            wait_ticks_d = '0;
        end else if (wait_mode_q && (wait_ticks_q != 32'hFFFF_FFFF)) begin
            wait_ticks_d = wait_ticks_q + 1'b1;
        end

        if ((state_q == ST_HIRED) && btn_end) begin
            fare_d       = meter_total;
            trip_count_d = trip_count_q + 1'b1;
        end
    end

    // Control outputs decoded from the next state so they flip together with the state register.
    always_comb begin
        meter_clr_d   = (state_d == ST_CLEAR);
        meter_en_d    = (state_d == ST_HIRED);
        fare_valid_d  = (state_d == ST_FARE);
        vacant_lamp_d = (state_d == ST_VACANT);
        wait_mode_d   = (state_d == ST_HIRED) && (gap_d == GAP_MAX);
    end

    // State and counter registers; reset aborts any trip in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_VACANT;
            clr_cnt_q    <= '0;
            disp_cnt_q   <= '0;
            gap_q        <= '0;
            wait_ticks_q <= '0;
            fare_q       <= '0;
            trip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            disp_cnt_q   <= disp_cnt_d;
            gap_q        <= gap_d;
            wait_ticks_q <= wait_ticks_d;
            fare_q       <= fare_d;
            trip_count_q <= trip_count_d;
        end
    end

    // Registered control outputs; the lamp is lit in reset because reset means vacant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meter_clr_q   <= 1'b0;
            meter_en_q    <= 1'b0;
            fare_valid_q  <= 1'b0;
            vacant_lamp_q <= 1'b1;
            wait_mode_q   <= 1'b0;
            pulse_out_q   <= 1'b0;
        end else begin
            meter_clr_q   <= meter_clr_d;
            meter_en_q    <= meter_en_d;
            fare_valid_q  <= fare_valid_d;
            vacant_lamp_q <= vacant_lamp_d;
            wait_mode_q   <= wait_mode_d;
            pulse_out_q   <= pulse_out_d;
        end
    end

    assign state       = state_q;
    assign meter_clr   = meter_clr_q;
    assign meter_en    = meter_en_q;
    assign pulse_out   = pulse_out_q;
    assign wait_mode   = wait_mode_q;
    assign wait_ticks  = wait_ticks_q;
    assign fare        = fare_q;
    assign fare_valid  = fare_valid_q;
    assign vacant_lamp = vacant_lamp_q;
    assign trip_count  = trip_count_q;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Purpose: self-checking bench for taxi_trip_ctrl against a timestamp-based trip model.
// Latency: model predicts outputs after every rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: none; stimulus is single-cycle strobes driven between edges.
`timescale 1ns/1ps
module tb_taxi_trip_ctrl;

    localparam int SLOW    = 5000;
    localparam int CLRC    = 2;
    localparam int DISP    = 30000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        distance_pulse_10m;
    logic        btn_hire;
    logic        btn_end;
    logic        btn_pay;
    logic [31:0] meter_total;
    logic        meter_clr;
    logic        meter_en;
    logic        pulse_out;
    logic        wait_mode;
    logic [31:0] wait_ticks;
    logic [1:0]  state;
    logic [31:0] fare;
    logic        fare_valid;
    logic        vacant_lamp;
    logic [15:0] trip_count;

    int n_total = 0;
    int n_bad   = 0;

    taxi_trip_ctrl #(
        .SLOW_TICKS    (SLOW),
        .CLR_CYCLES    (CLRC),
        .DISPLAY_TICKS (DISP)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .distance_pulse_10m (distance_pulse_10m),
        .btn_hire           (btn_hire),
        .btn_end            (btn_end),
        .btn_pay            (btn_pay),
        .meter_total        (meter_total),
        .meter_clr          (meter_clr),
        .meter_en           (meter_en),
        .pulse_out          (pulse_out),
        .wait_mode          (wait_mode),
        .wait_ticks         (wait_ticks),
        .state              (state),
        .fare               (fare),
        .fare_valid         (fare_valid),
        .vacant_lamp        (vacant_lamp),
        .trip_count         (trip_count)
    );

    always #5 clk = ~clk;

    // Reference model: trip phase plus timestamps of the events that matter.
    logic [1:0]  m_st;
    logic        m_wm;
    logic        m_po;
    logic [31:0] m_fare;
    logic [31:0] m_wt;
    logic [15:0] m_trips;
    longint      cyc;
    longint      t_enter;
    longint      quiet_start;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = 2'd0;
        m_wm    = 1'b0;
        m_po    = 1'b0;
        m_fare  = '0;
        m_wt    = '0;
        m_trips = '0;
        t_enter = cyc;
        quiet_start = cyc;
    endtask

    task automatic model_edge();
        logic [1:0] old_st;
        logic [1:0] nst;
        logic       old_wm;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_st = m_st;
        old_wm = m_wm;
        nst    = m_st;
        if (old_st == 2'd2 && distance_pulse_10m) quiet_start = cyc;
        case (old_st)
            2'd0: if (btn_hire) begin nst = 2'd1; t_enter = cyc; end
            2'd1: if (cyc - t_enter >= longint'(CLRC)) begin nst = 2'd2; quiet_start = cyc; end
            2'd2: if (btn_end) begin
                      nst = 2'd3; t_enter = cyc; m_fare = meter_total; m_trips = m_trips + 16'd1;
                  end
            default: if (btn_pay || (cyc - t_enter >= longint'(DISP))) nst = 2'd0;
        endcase
        if (old_st == 2'd1) m_wt = '0;
        else if (old_wm && m_wt != 32'hFFFF_FFFF) m_wt = m_wt + 32'd1;
        m_po = distance_pulse_10m && (old_st == 2'd2);
        m_st = nst;
        m_wm = (nst == 2'd2) && ((cyc - quiet_start) >= longint'(SLOW));
    endtask

    task automatic check_all(input string tag);
        logic [87:0] got;
        logic [87:0] exp;
        got = {state, meter_clr, meter_en, pulse_out, wait_mode, fare_valid, vacant_lamp,
               fare, wait_ticks, trip_count};
        exp = {m_st, m_st == 2'd1, m_st == 2'd2, m_po, m_wm, m_st == 2'd3, m_st == 2'd0,
               m_fare, m_wt, m_trips};
        check_val(tag, {40'd0, got}, {40'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("outputs");
    endtask

    task automatic drive(input logic h, input logic e, input logic p, input logic d);
        btn_hire = h; btn_end = e; btn_pay = p; distance_pulse_10m = d;
        step();
        btn_hire = 1'b0; btn_end = 1'b0; btn_pay = 1'b0; distance_pulse_10m = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Two pulses spaced 250 cycles apart; pulse_out must follow only when hired.
    task automatic pulse_pair(input string tag, input logic exp_po);
        for (int k = 0; k < 2; k++) begin
            idle(248);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            check_val({tag, "_po"}, pulse_out, exp_po);
            idle(1);
            check_val({tag, "_po_after"}, pulse_out, 1'b0);
        end
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b1;
        distance_pulse_10m = 1'b0; btn_hire = 1'b0; btn_end = 1'b0; btn_pay = 1'b0;
        meter_total = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_all("reset_async");
        check_val("reset_lamp", vacant_lamp, 1'b1);
        step();
        step();
        rst_n = 1'b1;

        // Trip start: noise in VACANT for cycles 0..9, hire in cycle 10.
        for (int i = 0; i < 10; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_val("vacant_ignores", state, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("clr_c11", {state, meter_clr, meter_en}, {2'd1, 1'b1, 1'b0});
        idle(1);
        check_val("clr_c12", {state, meter_clr, meter_en}, {2'd1, 1'b1, 1'b0});
        idle(1);
        check_val("hired_c13", {state, meter_clr, meter_en}, {2'd2, 1'b0, 1'b1});

        // Pulse gating while hired, then wait mode after a long quiet stretch.
        pulse_pair("hired_a", 1'b1);
        pulse_pair("hired_b", 1'b1);
        idle(SLOW - 2);
        check_val("wm_before", wait_mode, 1'b0);
        idle(1);
        check_val("wm_rise", {wait_mode, wait_ticks}, {1'b1, 32'd0});
        idle(3000);
        check_val("wait_3000", {wait_mode, wait_ticks}, {1'b1, 32'd3000});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("wm_drop", {wait_mode, pulse_out}, {1'b0, 1'b1});

        // Trip end and payment.
        meter_total = 32'd1234;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("end_fare", {state, fare, fare_valid, meter_en, trip_count},
                  {2'd3, 32'd1234, 1'b1, 1'b0, 16'd1});
        pulse_pair("fare", 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("fare_ignores", state, 2'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("pay_vacant", {state, vacant_lamp, fare}, {2'd0, 1'b1, 32'd1234});
        pulse_pair("vacant", 1'b0);

        // Randomised traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            meter_total = $urandom;
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0);
        end

        // Display timeout with a simultaneous hire+end.
        for (int i = 0; i < 100 && m_st != 2'd2; i++)
            drive(m_st == 2'd0, 1'b0, m_st == 2'd3, 1'b0);
        check_val("steer_hired", state, 2'd2);
        meter_total = 32'd777;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("both_btn", {state, fare}, {2'd3, 32'd777});
        idle(DISP - 1);
        check_val("disp_hold", {state, fare_valid}, {2'd3, 1'b1});
        idle(1);
        check_val("disp_timeout", {state, vacant_lamp, fare_valid}, {2'd0, 1'b1, 1'b0});

        // Reset mid-trip: fresh reset, start a trip, then pull reset with end pending.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(CLRC);
        check_val("rst_trip_hired", state, 2'd2);
        meter_total = 32'd999;
        btn_end = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_async", {state, fare, trip_count, meter_en, vacant_lamp},
                  {2'd0, 32'd0, 16'd0, 1'b0, 1'b1});
        check_all("rst_async_all");
        step();
        btn_end = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("first_edge", {state, fare, trip_count}, {2'd1, 32'd0, 16'd0});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
